// File: rtl/exec_sequencer_if.sv
// Issue-side bundle of the exec sequencer: instruction handshake, stall input and datapath controls.
// retire_count exists only when EXEC_SEQ_RETIRE_CNT_EN is defined.
interface exec_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [31:0]      instr_data;
  logic             instr_ready;
  logic             hold;
  logic [4:0]       rf_raddr;
  logic [4:0]       rf_waddr;
  logic             rf_we;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_imm;
  logic             busy;
  logic             illegal;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_count;
`endif

  // master: instruction source / harness; slave: the sequencer
  modport master (
    output instr_valid, instr_data, hold,
    input  instr_ready, rf_raddr, rf_waddr, rf_we, alu_op, alu_imm, busy, illegal
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    , input retire_count
`endif
  );

  modport slave (
    input  instr_valid, instr_data, hold,
    output instr_ready, rf_raddr, rf_waddr, rf_we, alu_op, alu_imm, busy, illegal
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    , output retire_count
`endif
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle OP-IMM issue controller: IDLE -> READ -> EXEC (hold-able) -> WRITE.
// Optional retire counter enabled by defining EXEC_SEQ_RETIRE_CNT_EN.
module exec_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  exec_sequencer_if.slave  bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  generate
    if (WIDTH < 12 || CNT_W < 1) begin : g_cfg_check
      $error("exec_sequencer: WIDTH must be >= 12 and CNT_W >= 1");
    end
  endgenerate

  function automatic logic signed [WIDTH-1:0] sext_imm12(input logic [11:0] imm);
    return {{(WIDTH-12){imm[11]}}, imm};
  endfunction

  state_e                  state_q, state_d;
  logic [4:0]              raddr_q, raddr_d;
  logic [4:0]              waddr_q, waddr_d;
  logic [2:0]              op_q, op_d;
  logic signed [WIDTH-1:0] imm_q, imm_d;
  logic                    legal_q, legal_d;
  logic                    we_q, we_d;
  logic                    ill_q, ill_d;
  logic                    ready_w;
  logic                    busy_w;

  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd;
  logic [2:0]  dec_f3;
  logic [4:0]  dec_rs1;
  logic [11:0] dec_imm12;

  assign dec_opcode = bus.instr_data[6:0];
  assign dec_rd     = bus.instr_data[11:7];
  assign dec_f3     = bus.instr_data[14:12];
  assign dec_rs1    = bus.instr_data[19:15];
  assign dec_imm12  = bus.instr_data[31:20];

`ifdef EXEC_SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    op_d    = op_q;
    imm_d   = imm_q;
    legal_d = legal_q;
    we_d    = 1'b0;
    ill_d   = 1'b0;
    ready_w = 1'b0;
    busy_w  = 1'b1;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready_w = 1'b1;
        busy_w  = 1'b0;
        if (bus.instr_valid) begin
          raddr_d = dec_rs1;
          waddr_d = dec_rd;
          op_d    = dec_f3;
          imm_d   = sext_imm12(dec_imm12);
          legal_d = (dec_opcode == OPC_OP_IMM);
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        // write strobes are registered, so they are computed on the EXEC->WRITE edge
        if (!bus.hold) begin
          state_d = WRITE;
          we_d    = legal_q && (waddr_q != 5'd0);
          ill_d   = !legal_q;
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        if (legal_q) cnt_d = cnt_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      raddr_q <= '0;
      waddr_q <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      legal_q <= 1'b0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      legal_q <= legal_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.instr_ready = ready_w && !rst;
  assign bus.busy        = busy_w;
  assign bus.rf_raddr    = raddr_q;
  assign bus.rf_waddr    = waddr_q;
  assign bus.rf_we       = we_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_imm     = imm_q;
  assign bus.illegal     = ill_q;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
  assign bus.retire_count = cnt_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: OP-IMM issue, x0 writes, illegal words, hold stall, reset mid-flight.
module tb_exec_sequencer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  int   exp_cnt;

  exec_sequencer_if #(.WIDTH(32), .CNT_W(16)) bus ();

  exec_sequencer #(.WIDTH(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    chk(tag, 32'(bus.retire_count), 32'(exp_cnt));
`else
    n_chk = n_chk;
`endif
  endtask

  // Entered during an IDLE cycle; leaves the bench in the IDLE cycle after retire.
  task automatic run_instr(input logic [31:0] word, input logic [4:0] e_rs1, input logic [4:0] e_rd,
                           input logic [2:0] e_f3, input logic [31:0] e_imm, input logic e_legal,
                           input int n_hold, input logic hold_early, input logic keep_valid);
    logic e_we;
    e_we = e_legal && (e_rd != 5'd0);
    bus.instr_valid = 1'b1;
    bus.instr_data  = word;
    bus.hold        = hold_early;
    chk("idle_ready", 32'(bus.instr_ready), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    tick();
    // READ
    if (!keep_valid) bus.instr_valid = 1'b0;
    chk("read_ready", 32'(bus.instr_ready), 32'd0);
    chk("read_busy", 32'(bus.busy), 32'd1);
    chk("read_raddr", 32'(bus.rf_raddr), 32'(e_rs1));
    chk("read_op", 32'(bus.alu_op), 32'(e_f3));
    chk("read_imm", bus.alu_imm, e_imm);
    chk("read_we", 32'(bus.rf_we), 32'd0);
    tick();
    // EXEC
    chk("exec_we", 32'(bus.rf_we), 32'd0);
    chk("exec_ready", 32'(bus.instr_ready), 32'd0);
    for (int i = 0; i < n_hold; i++) begin
      bus.hold = 1'b1;
      tick();
      chk("hold_we", 32'(bus.rf_we), 32'd0);
      chk("hold_busy", 32'(bus.busy), 32'd1);
      chk("hold_ready", 32'(bus.instr_ready), 32'd0);
      chk("hold_raddr", 32'(bus.rf_raddr), 32'(e_rs1));
      chk("hold_imm", bus.alu_imm, e_imm);
    end
    bus.hold = 1'b0;
    tick();
    // WRITE
    chk("wr_we", 32'(bus.rf_we), 32'(e_we));
    chk("wr_waddr", 32'(bus.rf_waddr), 32'(e_rd));
    chk("wr_illegal", 32'(bus.illegal), 32'(!e_legal));
    chk("wr_raddr", 32'(bus.rf_raddr), 32'(e_rs1));
    chk("wr_op", 32'(bus.alu_op), 32'(e_f3));
    chk("wr_imm", bus.alu_imm, e_imm);
    chk("wr_ready", 32'(bus.instr_ready), 32'd0);
    tick();
    // back in IDLE
    if (e_legal) exp_cnt++;
    chk("post_we", 32'(bus.rf_we), 32'd0);
    chk("post_illegal", 32'(bus.illegal), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_ready", 32'(bus.instr_ready), 32'd1);
    chk("post_imm", bus.alu_imm, e_imm);
    chk("post_waddr", 32'(bus.rf_waddr), 32'(e_rd));
    chk_cnt("post_cnt");
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_raddr"}, 32'(bus.rf_raddr), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'd0);
    chk({tag, "_op"}, 32'(bus.alu_op), 32'd0);
    chk({tag, "_imm"}, bus.alu_imm, 32'd0);
    chk({tag, "_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 32'h0;
    bus.hold        = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.instr_ready), 32'd0);
    chk_zero_outputs("rst");
    chk_cnt("rst_cnt");
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(bus.instr_ready), 32'd1);
    tick();

    // addi x5, x1, 0x7FF
    run_instr(32'h7FF0_8293, 5'd1, 5'd5, 3'd0, 32'h0000_07FF, 1'b1, 0, 1'b0, 1'b0);
    // addi x3, x2, -1
    run_instr(32'hFFF1_0193, 5'd2, 5'd3, 3'd0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b0);
    // R-type word: illegal pulse, no write, not counted
    run_instr(32'h0000_0033, 5'd0, 5'd0, 3'd0, 32'h0000_0000, 1'b0, 0, 1'b0, 1'b0);
    // hold raised already in IDLE (ignored there and in READ), 5 stall cycles in EXEC
    run_instr(32'hFFF1_0193, 5'd2, 5'd3, 3'd0, 32'hFFFF_FFFF, 1'b1, 5, 1'b1, 1'b0);

    // reset while in EXEC discards the instruction
    bus.instr_valid = 1'b1;
    bus.instr_data  = 32'h7FF0_8293;
    tick();
    bus.instr_valid = 1'b0;
    chk("rx_read_raddr", 32'(bus.rf_raddr), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    exp_cnt = 0;
    chk("rx_ready", 32'(bus.instr_ready), 32'd0);
    chk_zero_outputs("rx");
    chk_cnt("rx_cnt");
    rst = 1'b0;
    #1;
    chk("rx_rel_ready", 32'(bus.instr_ready), 32'd1);
    tick();
    chk("rx_idle_we", 32'(bus.rf_we), 32'd0);
    chk("rx_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("rx_idle2_we", 32'(bus.rf_we), 32'd0);

    // back-to-back: valid never drops, second accept 4 cycles after the first
    run_instr(32'h7FF0_8293, 5'd1, 5'd5, 3'd0, 32'h0000_07FF, 1'b1, 0, 1'b0, 1'b1);
    run_instr(32'h0010_6013, 5'd0, 5'd0, 3'd6, 32'h0000_0001, 1'b1, 0, 1'b0, 1'b0);
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    chk("b2b_cnt_two", 32'(bus.retire_count), 32'd2);
`endif

    tick();
    chk("final_busy", 32'(bus.busy), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
